// File: rtl/mem_stage_ctrl.sv
`timescale 1ns/1ps
// Purpose: memory-stage controller; turns execute-stage ops into one aligned memory access or a passthrough result.
// Latency: valid_out 1 cycle after accept (non-memory/illegal), 1 cycle after the mem_ack edge (load/store).
// Backpressure: busy=1 outside IDLE; upstream holds valid_in until busy=0. A missing mem_ack ends in a timeout error.
//
// Ports: clk/rst (async active-low); execute side valid_in, readFlag_in, writeIn, size, signExt, addressIn,
// dataIn, busy; memory side mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_ack, mem_rdata;
// writeback side valid_out, dataOut, err.
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                readFlag_in,
    input  logic                writeIn,
    input  logic [1:0]          size,
    input  logic                signExt,
    input  logic [ADDR_W-1:0]   addressIn,
    input  logic [DATA_W-1:0]   dataIn,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                valid_out,
    output logic [DATA_W-1:0]   dataOut,
    output logic [1:0]          err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t state, state_nxt;

    logic [7:0]        cnt;
    logic [LANE_W-1:0] lane_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [1:0]        err_q;

    logic              is_mem;
    logic              illegal;
    logic [LANE_W-1:0] lane_in;
    logic [BE_W-1:0]   be_raw;
    logic [BE_W-1:0]   be_in;
    logic [DATA_W-1:0] data_lo;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;
    logic [DATA_W-1:0] load_val;

    assign is_mem  = readFlag_in | writeIn;
    assign lane_in = addressIn[LANE_W-1:0];

    // Alignment is judged on the byte address only; a 64-bit lane can hold a word at offset 0 or 4.
    assign illegal = (readFlag_in & writeIn)
                   | (size == 2'b11)
                   | ((size == 2'b01) & addressIn[0])
                   | ((size == 2'b10) & (addressIn[1:0] != 2'b00));

    // Store side: byte enables and data positioned at the lane.
    always_comb begin
        be_raw  = '0;
        data_lo = '0;
        case (size)
            2'b00:   begin be_raw = BE_W'(4'h1); data_lo = DATA_W'(dataIn[7:0]);  end
            2'b01:   begin be_raw = BE_W'(4'h3); data_lo = DATA_W'(dataIn[15:0]); end
            default: begin be_raw = BE_W'(4'hF); data_lo = DATA_W'(dataIn[31:0]); end
        endcase
        be_in    = be_raw << lane_in;
        wdata_in = data_lo << {lane_in, 3'b000};
    end

    // Load side: bring the lane down to bit 0, keep the access size, then extend.
    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        mask    = '0;
        sign    = 1'b0;
        case (size_q)
            2'b00:   begin mask = DATA_W'(8'hFF);         sign = shifted[7];  end
            2'b01:   begin mask = DATA_W'(16'hFFFF);      sign = shifted[15]; end
            default: begin mask = DATA_W'(32'hFFFF_FFFF); sign = shifted[31]; end
        endcase
        load_val = (shifted & mask) | ((sext_q && sign) ? ~mask : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (!is_mem)      state_nxt = RESP;
                    else if (illegal) state_nxt = ERR;
                    else              state_nxt = REQ;
                end
            end
            REQ: begin
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack)           state_nxt = RESP;
                else if (cnt <= 8'd1)  state_nxt = ERR;
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign valid_out = (state == RESP) || (state == ERR);
    assign err       = valid_out ? err_q : ERR_OK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            err_q     <= ERR_OK;
            dataOut   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        lane_q <= lane_in;
                        size_q <= size;
                        sext_q <= signExt;
                        if (!is_mem) begin
                            dataOut <= DATA_W'(addressIn);
                            err_q   <= ERR_OK;
                        end else if (illegal) begin
                            dataOut <= '0;
                            err_q   <= ERR_ALIGN;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= writeIn;
                            mem_addr  <= {addressIn[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            mem_be    <= be_in;
                            mem_wdata <= wdata_in;
                            cnt       <= 8'(TIMEOUT);
                            err_q     <= ERR_OK;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        dataOut <= mem_we ? '0 : load_val;
                        err_q   <= ERR_OK;
                    end else begin
                        cnt <= cnt - 8'd1;
                        if (cnt <= 8'd1) begin
                            mem_req <= 1'b0;
                            dataOut <= '0;
                            err_q   <= ERR_TMO;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_stage_ctrl: directed ops with expected memory requests and results queued at issue time,
// compared by a negedge monitor whenever the DUT raises mem_req or valid_out.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        readFlag_in;
    logic        writeIn;
    logic [1:0]  size;
    logic        signExt;
    logic [31:0] addressIn;
    logic [31:0] dataIn;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        valid_out;
    logic [31:0] dataOut;
    logic [1:0]  err;

    mem_stage_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .readFlag_in(readFlag_in), .writeIn(writeIn),
        .size(size), .signExt(signExt), .addressIn(addressIn), .dataIn(dataIn), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .valid_out(valid_out), .dataOut(dataOut), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } mreq_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
    } res_t;

    mreq_t mq[$];
    res_t  rq[$];
    mreq_t cur;
    logic  have_cur;
    logic  req_prev;
    logic  vo_prev;
    int    req_len;
    int    last_req_len;
    int    vo_count;
    int    checks;
    int    errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_m(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
        mreq_t m;
        m.addr = a; m.be = be; m.wdata = wd; m.we = we;
        mq.push_back(m);
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] e);
        res_t r;
        r.data = d; r.err = e;
        rq.push_back(r);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_out) begin
                vo_count++;
                chk("valid_out_single", {31'b0, vo_prev}, 32'd0);
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_out actual=%h/%h required=none", dataOut, err);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("result_data", dataOut, r.data);
                    chk("result_err", {30'b0, err}, {30'b0, r.err});
                end
            end
            if (mem_req) begin
                if (!req_prev) begin
                    req_len = 0;
                    if (mq.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_mem_req actual=%h required=none", mem_addr);
                    end else begin
                        cur = mq.pop_front();
                        have_cur = 1'b1;
                    end
                end
                req_len++;
                if (have_cur) begin
                    chk("req_addr", mem_addr, cur.addr);
                    chk("req_be", {28'b0, mem_be}, {28'b0, cur.be});
                    chk("req_wdata", mem_wdata, cur.wdata);
                    chk("req_we", {31'b0, mem_we}, {31'b0, cur.we});
                end
            end else if (req_prev) begin
                last_req_len = req_len;
            end
            req_prev = mem_req;
            vo_prev  = valid_out;
        end else begin
            req_prev = 1'b0;
            vo_prev  = 1'b0;
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        readFlag_in = rd; writeIn = wr; size = sz; signExt = sx; addressIn = a; dataIn = d;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Called one step after the accept edge; acks after n ack-less REQ cycles.
    task automatic ack_after(input int n, input logic [31:0] rd);
        repeat (n) @(posedge clk);
        #1;
        mem_ack = 1'b1;
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("mem_req_drop_on_ack", {31'b0, mem_req}, 32'd0);
        chk("valid_after_ack", {31'b0, valid_out}, 32'd1);
        @(posedge clk); #1;
        chk("valid_one_cycle", {31'b0, valid_out}, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vo_before;
        checks = 0; errors = 0; vo_count = 0; req_len = 0; last_req_len = 0;
        have_cur = 1'b0; req_prev = 1'b0; vo_prev = 1'b0;
        rst = 1'b0; valid_in = 1'b0; readFlag_in = 1'b0; writeIn = 1'b0; size = 2'b00;
        signExt = 1'b0; addressIn = '0; dataIn = '0; mem_ack = 1'b0; mem_rdata = '0;

        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_err", {30'b0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Load byte at 0x1003, sign-extended
        push_m(32'h0000_1000, 4'b1000, 32'h0, 1'b0);
        push_r(32'hFFFF_FF80, 2'b00);
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
        ack_after(2, 32'h8012_3456);
        wait_idle();

        // Store half at 0x2002
        push_m(32'h0000_2000, 4'b1100, 32'hABCD_0000, 1'b1);
        push_r(32'h0, 2'b00);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
        ack_after(0, 32'hFFFF_FFFF);
        wait_idle();

        // Load half unsigned, lane 2
        push_m(32'h0000_4000, 4'b1100, 32'h0, 1'b0);
        push_r(32'h0000_8765, 2'b00);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0);
        ack_after(1, 32'h8765_1111);
        wait_idle();

        // Load byte zero-extended, lane 1
        push_m(32'h0000_5000, 4'b0010, 32'h0, 1'b0);
        push_r(32'h0000_00A5, 2'b00);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_5001, 32'h0);
        ack_after(0, 32'h0000_A500);
        wait_idle();

        // Load half signed, lane 0
        push_m(32'h0000_8000, 4'b0011, 32'h0, 1'b0);
        push_r(32'hFFFF_F123, 2'b00);
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_8000, 32'h0);
        ack_after(1, 32'h0000_F123);
        wait_idle();

        // Store byte, lane 1
        push_m(32'h0000_6000, 4'b0010, 32'h0000_7700, 1'b1);
        push_r(32'h0, 2'b00);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h1234_5677);
        ack_after(0, 32'h0);
        wait_idle();

        // Store word
        push_m(32'h0000_7004, 4'b1111, 32'hCAFE_F00D, 1'b1);
        push_r(32'h0, 2'b00);
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_7004, 32'hCAFE_F00D);
        ack_after(3, 32'h0);
        wait_idle();

        // Misaligned word load: error result one cycle after accept, no request
        push_r(32'h0, 2'b01);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        chk("misalign_valid_next", {31'b0, valid_out}, 32'd1);
        chk("misalign_no_req", {31'b0, mem_req}, 32'd0);
        wait_idle();

        // Illegal size, both flags, odd half
        push_r(32'h0, 2'b01);
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
        wait_idle();
        push_r(32'h0, 2'b01);
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
        wait_idle();
        push_r(32'h0, 2'b01);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_9001, 32'h5555);
        wait_idle();

        // Non-memory passthrough
        push_r(32'hDEAD_BEEF, 2'b00);
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0);
        chk("passthru_valid_next", {31'b0, valid_out}, 32'd1);
        @(posedge clk); #1;
        chk("passthru_valid_drop", {31'b0, valid_out}, 32'd0);
        wait_idle();

        // Timeout: no ack, 15 request cycles then ERR
        push_m(32'h0000_3000, 4'b1111, 32'h0, 1'b0);
        push_r(32'h0, 2'b10);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_busy_cycles", n, 32'd16);
        chk("timeout_req_len", last_req_len, 32'd15);

        // Ack while idle is ignored
        vo_before = vo_count;
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack_ignored", vo_count, vo_before);
        chk("idle_ack_busy", {31'b0, busy}, 32'd0);

        // valid_in held through busy: two accepts over four edges
        vo_before = vo_count;
        push_r(32'h1234_5678, 2'b00);
        push_r(32'h1234_5678, 2'b00);
        readFlag_in = 1'b0; writeIn = 1'b0; addressIn = 32'h1234_5678; valid_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        valid_in = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        chk("hold_accept_count", vo_count - vo_before, 32'd2);

        // Reset mid-request, then a stray ack
        push_m(32'h0000_A000, 4'b1111, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_A000, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        vo_before = vo_count;
        rst = 1'b0;
        #1;
        chk("midreq_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("midreq_rst_busy", {31'b0, busy}, 32'd0);
        chk("midreq_rst_dataOut", dataOut, 32'd0);
        chk("midreq_rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_valid", vo_count, vo_before);
        chk("post_rst_no_req", {31'b0, mem_req}, 32'd0);

        // Clean operation after reset
        push_r(32'h55AA_55AA, 2'b00);
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h55AA_55AA, 32'h0);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("mreq_queue_drained", mq.size(), 32'd0);
        chk("result_queue_drained", rq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
